// File: rtl/cmd_timing_gate.sv
// ============================================================================
// cmd_timing_gate : holds one scheduler command until per-bank busy flags and
// rank-level tRRD / tCCD / tFAW allow it onto the command bus.
// Optional feature macro: TIMING_WATCHDOG_EN (sticky hold-time watchdog).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cmd_timing_gate #(
  parameter int BA_BITS    = 3,
  parameter int TRRD       = 4,
  parameter int TCCD       = 4,
  parameter int TFAW       = 20,
  parameter int WDOG_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_cmd,
  input  logic [BA_BITS-1:0]      req_bank,
  input  logic                    req_auto_pre,
  input  logic [(1<<BA_BITS)-1:0] bank_tp_busy,
  input  logic [(1<<BA_BITS)-1:0] bank_tras_busy,
  output logic                    iss_valid,
  output logic [2:0]              iss_cmd,
  output logic [BA_BITS-1:0]      iss_bank,
  output logic                    iss_auto_pre,
  output logic                    wdog_err
);

  localparam int RRD_W = (TRRD > 1) ? $clog2(TRRD) : 1;
  localparam int CCD_W = (TCCD > 1) ? $clog2(TCCD) : 1;
  localparam int FAW_W = (TFAW > 1) ? $clog2(TFAW) : 1;

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state;
  logic [2:0]           hold_cmd;
  logic [BA_BITS-1:0]   hold_bank;
  logic                 hold_auto_pre;
  logic [RRD_W-1:0]     rrd_cnt;
  logic [CCD_W-1:0]     ccd_cnt;
  logic [FAW_W-1:0]     faw_slot [4];

  logic                 ok;
  logic                 issue;
  logic                 accept;
  logic                 issue_act;
  logic                 issue_col;
  logic [2:0]           faw_used;
  logic [1:0]           faw_free_idx;

  always_comb begin
    faw_used     = 3'd0;
    faw_free_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (faw_slot[i] != '0) faw_used = faw_used + 3'd1;
    end
    // Scan downward so the lowest-index free slot wins.
    for (int i = 3; i >= 0; i--) begin
      if (faw_slot[i] == '0) faw_free_idx = 2'(i);
    end
  end

  always_comb begin
    ok = 1'b0;
    case (hold_cmd)
      CMD_ACT: ok = !bank_tp_busy[hold_bank] && (rrd_cnt == '0) && (faw_used < 3'd4);
      CMD_RD,
      CMD_WR:  ok = !bank_tp_busy[hold_bank] && (ccd_cnt == '0);
      CMD_PRE: ok = !bank_tp_busy[hold_bank] && !bank_tras_busy[hold_bank];
      CMD_REF: ok = (bank_tp_busy == '0) && (bank_tras_busy == '0);
      default: ok = 1'b1;
    endcase
  end

  assign issue     = (state == HOLD) && ok;
  assign req_ready = !rst && ((state == IDLE) || ok);
  assign accept    = req_valid && req_ready;
  assign issue_act = issue && (hold_cmd == CMD_ACT);
  assign issue_col = issue && ((hold_cmd == CMD_RD) || (hold_cmd == CMD_WR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold_cmd      <= 3'd0;
      hold_bank     <= '0;
      hold_auto_pre <= 1'b0;
      iss_valid     <= 1'b0;
      iss_cmd       <= 3'd0;
      iss_bank      <= '0;
      iss_auto_pre  <= 1'b0;
    end else begin
      iss_valid <= issue;
      if (issue) begin
        iss_cmd      <= hold_cmd;
        iss_bank     <= hold_bank;
        iss_auto_pre <= hold_auto_pre;
      end
      case (state)
        IDLE: begin
          if (accept) state <= HOLD;
        end
        HOLD: begin
          // A new command can only be taken in the cycle the held one leaves.
          if (issue && !accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        hold_cmd      <= req_cmd;
        hold_bank     <= req_bank;
        hold_auto_pre <= req_auto_pre;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      for (int i = 0; i < 4; i++) faw_slot[i] <= '0;
    end else begin
      if (issue_act)          rrd_cnt <= RRD_W'(TRRD - 1);
      else if (rrd_cnt != '0) rrd_cnt <= rrd_cnt - 1'b1;

      if (issue_col)          ccd_cnt <= CCD_W'(TCCD - 1);
      else if (ccd_cnt != '0) ccd_cnt <= ccd_cnt - 1'b1;

      for (int i = 0; i < 4; i++) begin
        if (issue_act && (faw_free_idx == 2'(i))) faw_slot[i] <= FAW_W'(TFAW - 1);
        else if (faw_slot[i] != '0)               faw_slot[i] <= faw_slot[i] - 1'b1;
      end
    end
  end

`ifdef TIMING_WATCHDOG_EN
  localparam logic [7:0] WD_LIM = 8'(WDOG_LIMIT);

  logic [7:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= 8'd0;
      wdog_err <= 1'b0;
    end else begin
      if (accept || issue) begin
        wd_cnt <= 8'd0;
      end else if (state == HOLD) begin
        // Saturate at the limit; the held command is never dropped.
        if (wd_cnt != WD_LIM) wd_cnt <= wd_cnt + 8'd1;
        if (wd_cnt + 8'd1 == WD_LIM) wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmd_timing_gate.sv
// ============================================================================
// tb_cmd_timing_gate : directed vector table plus multi-cycle sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cmd_timing_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_cmd;
  logic [2:0] req_bank;
  logic       req_auto_pre;
  logic [7:0] bank_tp_busy;
  logic [7:0] bank_tras_busy;
  logic       iss_valid;
  logic [2:0] iss_cmd;
  logic [2:0] iss_bank;
  logic       iss_auto_pre;
  logic       wdog_err;

  cmd_timing_gate #(
    .BA_BITS(3), .TRRD(4), .TCCD(4), .TFAW(20), .WDOG_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_bank(req_bank), .req_auto_pre(req_auto_pre),
    .bank_tp_busy(bank_tp_busy), .bank_tras_busy(bank_tras_busy),
    .iss_valid(iss_valid), .iss_cmd(iss_cmd), .iss_bank(iss_bank),
    .iss_auto_pre(iss_auto_pre), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

`ifdef TIMING_WATCHDOG_EN
  localparam logic EXP_WD = 1'b1;
`else
  localparam logic EXP_WD = 1'b0;
`endif

  typedef struct {
    logic [2:0] cmd;
    logic [2:0] bank;
    logic       ap;
    logic [7:0] tp;
    logic [7:0] tras;
    int         hold;
  } vec_t;

  vec_t vecs [12];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int iss_n  = 0;
  int         iss_t [64];
  logic [2:0] iss_c [64];
  logic [2:0] iss_b [64];
  logic       iss_a [64];

  // Issue monitor: edge index of every iss_valid strobe.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (iss_valid && iss_n < 64) begin
      iss_t[iss_n] = cyc;
      iss_c[iss_n] = iss_cmd;
      iss_b[iss_n] = iss_bank;
      iss_a[iss_n] = iss_auto_pre;
      iss_n = iss_n + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_issues(input string name, input int n, input int lim);
    int k = 0;
    while (iss_n < n && k < lim) begin
      step();
      k++;
    end
    chk({name, "_timeout"}, (iss_n >= n) ? 1 : 0, 1);
  endtask

  // Offers one command and returns once it has been accepted; req_valid stays up.
  task automatic send(input logic [2:0] c, input logic [2:0] b, input logic ap, output int acc);
    logic r;
    int   k = 0;
    req_valid    = 1'b1;
    req_cmd      = c;
    req_bank     = b;
    req_auto_pre = ap;
    acc          = -1;
    while (acc < 0 && k < 100) begin
      #1;
      r = req_ready;
      @(posedge clk);
      #2;
      if (r) acc = cyc;
      k++;
    end
    if (acc < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int base;
    int acc;
    string nm;
    nm = $sformatf("vec%0d", idx);
    base           = iss_n;
    bank_tp_busy   = v.tp;
    bank_tras_busy = v.tras;
    req_valid      = 1'b1;
    req_cmd        = v.cmd;
    req_bank       = v.bank;
    req_auto_pre   = v.ap;
    #1;
    chk({nm, "_ready"}, int'(req_ready), 1);
    @(posedge clk);
    #2;
    acc       = cyc;
    req_valid = 1'b0;
    idle(v.hold);
    bank_tp_busy   = 8'h00;
    bank_tras_busy = 8'h00;
    wait_issues(nm, base + 1, 10);
    if (iss_n > base) begin
      chk({nm, "_latency"}, iss_t[base] - acc, v.hold + 1);
      chk({nm, "_cmd"},  int'(iss_c[base]), int'(v.cmd));
      chk({nm, "_bank"}, int'(iss_b[base]), int'(v.bank));
      chk({nm, "_ap"},   int'(iss_a[base]), int'(v.ap));
    end
    idle(22);
  endtask

  initial begin
    int base;
    int acc;

    vecs[0]  = '{3'd1, 3'd2, 1'b0, 8'h00, 8'h00, 0};  // ACT, nothing busy
    vecs[1]  = '{3'd2, 3'd5, 1'b1, 8'h20, 8'h00, 3};  // RD waits on own tP
    vecs[2]  = '{3'd3, 3'd1, 1'b0, 8'h00, 8'hFF, 0};  // WR ignores tRAS
    vecs[3]  = '{3'd4, 3'd3, 1'b0, 8'h00, 8'h08, 6};  // PRE waits on own tRAS
    vecs[4]  = '{3'd4, 3'd3, 1'b0, 8'hF7, 8'hF7, 0};  // PRE, only other banks busy
    vecs[5]  = '{3'd4, 3'd2, 1'b0, 8'h04, 8'h00, 2};  // PRE waits on own tP
    vecs[6]  = '{3'd5, 3'd0, 1'b0, 8'h80, 8'h00, 4};  // REF blocked by any tP
    vecs[7]  = '{3'd5, 3'd0, 1'b0, 8'h00, 8'h02, 2};  // REF blocked by any tRAS
    vecs[8]  = '{3'd0, 3'd6, 1'b0, 8'hFF, 8'hFF, 0};  // NOP code 0 never blocks
    vecs[9]  = '{3'd7, 3'd4, 1'b1, 8'hFF, 8'hFF, 0};  // NOP code 7 never blocks
    vecs[10] = '{3'd1, 3'd7, 1'b0, 8'h40, 8'h80, 0};  // ACT, other bank busy
    vecs[11] = '{3'd1, 3'd6, 1'b0, 8'h40, 8'h00, 5};  // ACT waits on own tP

    rst = 1'b1;
    req_valid = 1'b0;
    req_cmd = 3'd0;
    req_bank = 3'd0;
    req_auto_pre = 1'b0;
    bank_tp_busy = 8'h00;
    bank_tras_busy = 8'h00;
    idle(3);
    chk("rst_ready",    int'(req_ready), 0);
    chk("rst_iss_valid", int'(iss_valid), 0);
    chk("rst_iss_cmd",  int'(iss_cmd), 0);
    chk("rst_wdog",     int'(wdog_err), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(req_ready), 1);
    idle(2);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // tRRD: two ACTs offered back-to-back
    base = iss_n;
    send(3'd1, 3'd0, 1'b0, acc);
    send(3'd1, 3'd1, 1'b0, acc);
    req_valid = 1'b0;
    wait_issues("trrd", base + 2, 30);
    if (iss_n >= base + 2) begin
      chk("trrd_gap", iss_t[base+1] - iss_t[base], 4);
      chk("trrd_bank", int'(iss_b[base+1]), 1);
    end
    idle(25);

    // tFAW: five ACTs to banks 0..4
    base = iss_n;
    for (int i = 0; i < 5; i++) send(3'd1, 3'(i), 1'b0, acc);
    req_valid = 1'b0;
    wait_issues("tfaw", base + 5, 60);
    if (iss_n >= base + 5) begin
      chk("tfaw_2nd", iss_t[base+1] - iss_t[base], 4);
      chk("tfaw_3rd", iss_t[base+2] - iss_t[base], 8);
      chk("tfaw_4th", iss_t[base+3] - iss_t[base], 12);
      chk("tfaw_5th", iss_t[base+4] - iss_t[base], 20);
      chk("tfaw_5th_bank", int'(iss_b[base+4]), 4);
    end
    idle(25);

    // tCCD: RD then WR
    base = iss_n;
    send(3'd2, 3'd0, 1'b0, acc);
    send(3'd3, 3'd3, 1'b1, acc);
    req_valid = 1'b0;
    wait_issues("tccd", base + 2, 30);
    if (iss_n >= base + 2) begin
      chk("tccd_gap", iss_t[base+1] - iss_t[base], 4);
      chk("tccd_ap", int'(iss_a[base+1]), 1);
    end
    idle(25);

    // ACT then RD: independent rules, so one issue per cycle
    base = iss_n;
    send(3'd1, 3'd0, 1'b0, acc);
    send(3'd2, 3'd0, 1'b0, acc);
    req_valid = 1'b0;
    wait_issues("b2b", base + 2, 10);
    if (iss_n >= base + 2) chk("b2b_gap", iss_t[base+1] - iss_t[base], 1);
    idle(25);

    // Reset while a RD is held
    base = iss_n;
    bank_tp_busy = 8'h04;
    send(3'd2, 3'd2, 1'b0, acc);
    req_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", int'(req_ready), 0);
    idle(2);
    rst = 1'b0;
    bank_tp_busy = 8'h00;
    #1;
    chk("midrst_ready_high", int'(req_ready), 1);
    idle(6);
    chk("midrst_no_issue", iss_n - base, 0);

    // Watchdog: WR held by tP
    base = iss_n;
    bank_tp_busy = 8'h02;
    send(3'd3, 3'd1, 1'b0, acc);
    req_valid = 1'b0;
    idle(4);
    chk("wdog_early", int'(wdog_err), 0);
    idle(6);
    chk("wdog_set", int'(wdog_err), int'(EXP_WD));
    bank_tp_busy = 8'h00;
    wait_issues("wdog", base + 1, 10);
    if (iss_n > base) chk("wdog_issue_cmd", int'(iss_c[base]), 3);
    idle(2);
    chk("wdog_sticky", int'(wdog_err), int'(EXP_WD));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #1;
    chk("wdog_rst", int'(wdog_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
